// File: rtl/pc_fetch_unit.sv
// RV32I program counter and instruction fetch with a small PC-tagged instruction buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter int               P_WIDTH      = 31,
  parameter logic [P_WIDTH:0] P_RESET_PC   = '0,
  parameter int               P_FIFO_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [P_WIDTH:0]   o_add_a,
  output logic [P_WIDTH:0]   o_add_b,
  input  logic [P_WIDTH:0]   i_add_y,
  output logic               o_imem_req,
  output logic [P_WIDTH:0]   o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [31:0]        i_imem_rdata,
  input  logic               i_redirect,
  input  logic [P_WIDTH:0]   i_redirect_pc,
  output logic               o_instr_valid,
  output logic [31:0]        o_instr,
  output logic [P_WIDTH:0]   o_instr_pc,
  input  logic               i_instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               o_misalign
`endif
);

  localparam int W  = P_WIDTH + 1;
  localparam int PW = $clog2(P_FIFO_DEPTH);
  localparam int CW = $clog2(P_FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(P_FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = P_FIFO_DEPTH[CW:0];

  logic [P_WIDTH:0] pc, infl_pc, last_pc, redir_target;
  logic             infl, halt, redir_load;
  logic [31:0]      fifo_instr [P_FIFO_DEPTH];
  logic [P_WIDTH:0] fifo_pc    [P_FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;
  logic [31:0]      last_instr;
  logic             fire, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_target;

  always_comb begin
    bad_target   = i_redirect_pc[1:0] != 2'b00;
    redir_load   = i_redirect && !bad_target;
    redir_target = i_redirect_pc;
  end

  // A misaligned target parks fetch until the next aligned redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt       <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      o_misalign <= i_redirect && bad_target;
      if (i_redirect) halt <= bad_target;
    end
  end
`else
  always_comb begin
    halt         = 1'b0;
    redir_load   = i_redirect;
    redir_target = i_redirect_pc & ~W'(3);
  end
`endif

  always_comb begin
    o_add_a       = pc;
    o_add_b       = W'(4);
    o_imem_addr   = pc;
    o_instr_valid = count != '0;
    o_instr       = o_instr_valid ? fifo_instr[rd_ptr] : last_instr;
    o_instr_pc    = o_instr_valid ? fifo_pc[rd_ptr]    : last_pc;
    // Credit counts only state at the start of the cycle; a same-cycle pop is not reused.
    occ           = {1'b0, count} + {{CW{1'b0}}, infl};
    o_imem_req    = !i_rst && !halt && !i_redirect && (occ < DEPTH_C);
    fire          = o_imem_req && i_imem_gnt;
    push          = i_imem_rvalid && infl && !i_redirect;
    pop           = o_instr_valid && i_instr_ready && !i_redirect;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc         <= P_RESET_PC;
      infl       <= 1'b0;
      infl_pc    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else begin
      if (o_instr_valid) begin
        last_instr <= fifo_instr[rd_ptr];
        last_pc    <= fifo_pc[rd_ptr];
      end
      if (i_redirect) begin
        if (redir_load) pc <= redir_target;
        infl   <= 1'b0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (fire) begin
          pc      <= i_add_y;
          infl_pc <= pc;
        end
        infl <= fire || (infl && !push);
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= i_imem_rdata;
      fifo_pc[wr_ptr]    <= infl_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a depth-2 unit for most sequences and a depth-4
// unit for the full-rate stream. Define FETCH_MISALIGN_TRAP_EN to exercise the trap.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b0, ready = 1'b0, redir = 1'b0, rv_force = 1'b0;
  logic [31:0] rpc = '0;

  logic [31:0] add_a, add_b, add_y, addr, rdata, instr, ipc, md;
  logic        req, rvalid, ivalid, mv;
  logic [31:0] d_add_a, d_add_b, d_add_y, d_addr, d_rdata, d_instr, d_ipc, d_md;
  logic        d_req, d_rvalid, d_ivalid, d_mv;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign, d_misalign;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External adder and single-cycle instruction memory (data = ~address) for each unit.
  assign add_y   = add_a + add_b;
  assign d_add_y = d_add_a + d_add_b;
  assign rvalid  = mv | rv_force;
  assign rdata   = md;
  assign d_rvalid = d_mv;
  assign d_rdata  = d_md;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= 1'b0; md <= '0; d_mv <= 1'b0; d_md <= '0;
    end else begin
      mv <= req && gnt;     md <= ~addr;
      d_mv <= d_req && gnt; d_md <= ~d_addr;
    end
  end

  pc_fetch_unit #(.P_WIDTH(31), .P_RESET_PC(32'h0), .P_FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst), .o_add_a(add_a), .o_add_b(add_b), .i_add_y(add_y),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata), .i_redirect(redir), .i_redirect_pc(rpc),
    .o_instr_valid(ivalid), .o_instr(instr), .o_instr_pc(ipc), .i_instr_ready(ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_misalign(misalign)
`endif
  );

  pc_fetch_unit #(.P_WIDTH(31), .P_RESET_PC(32'h0), .P_FIFO_DEPTH(4)) u_deep (
    .i_clk(clk), .i_rst(rst), .o_add_a(d_add_a), .o_add_b(d_add_b), .i_add_y(d_add_y),
    .o_imem_req(d_req), .o_imem_addr(d_addr), .i_imem_gnt(gnt), .i_imem_rvalid(d_rvalid),
    .i_imem_rdata(d_rdata), .i_redirect(redir), .i_redirect_pc(rpc),
    .o_instr_valid(d_ivalid), .o_instr(d_instr), .o_instr_pc(d_ipc), .i_instr_ready(ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_misalign(d_misalign)
`endif
  );

  typedef struct {
    logic        gnt, rdy, redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] eipc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic r, input logic d, input logic [31:0] p);
    gnt = g; ready = r; redir = d; rpc = p;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; ready = 1'b0; redir = 1'b0; rpc = '0; rv_force = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_valid", ivalid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_add_b", add_b, 32'h4);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ready=0 until one single-cycle pop, then a flushing redirect at c10.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h10,  1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};

    // Full-rate stream on the deep unit; the depth-2 unit stalls on its credit limit.
    do_reset();
    drive(1, 1, 0, 0);
    chk("s1_c0_addr", d_addr, 32'h0);
    chk("s1_c0_req", d_req, 1);
    step(); drive(1, 1, 0, 0);
    chk("s1_c1_addr", d_addr, 32'h4);
    chk("s1_c1_valid", d_ivalid, 0);
    step(); drive(1, 1, 0, 0);
    chk("s1_c2_addr", d_addr, 32'h8);
    chk("s1_c2_ipc", d_ipc, 32'h0);
    chk("s1_c2_instr", d_instr, 32'hFFFF_FFFF);
    chk("s1_c2_shallow_req", req, 0);
    step(); drive(1, 1, 0, 0);
    chk("s1_c3_addr", d_addr, 32'hC);
    chk("s1_c3_ipc", d_ipc, 32'h4);
    chk("s1_c3_instr", d_instr, 32'hFFFF_FFFB);
    step(); drive(1, 1, 0, 0);
    chk("s1_c4_ipc", d_ipc, 32'h8);
    chk("s1_c4_valid", d_ivalid, 1);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].gnt, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      chk($sformatf("t%0d_req", i), req, tbl[i].ereq);
      chk($sformatf("t%0d_addr", i), addr, tbl[i].eaddr);
      chk($sformatf("t%0d_valid", i), ivalid, tbl[i].evalid);
      if (tbl[i].evalid) chk($sformatf("t%0d_ipc", i), ipc, tbl[i].eipc);
      step();
    end

    // Redirect while 0x8 is in flight: its response must never reach decode.
    do_reset();
    drive(1, 1, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 1, 0, 0);
    chk("s3_c3_addr", addr, 32'h8);
    chk("s3_c3_req", req, 1);
    step(); drive(1, 1, 1, 32'h100);
    chk("s3_redir_req", req, 0);
    step(); drive(1, 1, 0, 0);
    chk("s3_post_valid", ivalid, 0);
    chk("s3_post_addr", addr, 32'h100);
    chk("s3_post_req", req, 1);
    step(); drive(1, 1, 0, 0);
    chk("s3_c6_valid", ivalid, 0);
    step(); drive(1, 1, 0, 0);
    chk("s3_c7_valid", ivalid, 1);
    chk("s3_c7_ipc", ipc, 32'h100);

    // PC wrap through the adder.
    step(); drive(1, 1, 1, 32'hFFFF_FFFC);
    chk("s4_redir_req", req, 0);
    step(); drive(1, 1, 0, 0);
    chk("s4_top_addr", addr, 32'hFFFF_FFFC);
    chk("s4_top_valid", ivalid, 0);
    step(); drive(1, 1, 0, 0);
    chk("s4_wrap_addr", addr, 32'h0);
    chk("s4_wrap_req", req, 1);

    // Misaligned redirect target.
    step(); drive(1, 1, 1, 32'h102);
    chk("s5_redir_req", req, 0);
    step(); drive(1, 1, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("s5_misalign_on", misalign, 1);
    chk("s5_halt_req", req, 0);
    step(); drive(1, 1, 0, 0);
    chk("s5_misalign_off", misalign, 0);
    chk("s5_halt_req2", req, 0);
    step(); drive(1, 1, 1, 32'h200);
    step(); drive(1, 1, 0, 0);
    chk("s5_resume_addr", addr, 32'h200);
    chk("s5_resume_req", req, 1);
`else
    chk("s5_align_addr", addr, 32'h100);
    chk("s5_align_req", req, 1);
    chk("s5_align_valid", ivalid, 0);
`endif

    // Reset with an entry buffered and a response in flight.
    do_reset();
    drive(1, 0, 0, 0); step();
    drive(1, 0, 0, 0); step();
    drive(1, 0, 0, 0);
    chk("s6_pre_valid", ivalid, 1);
    chk("s6_pre_addr", addr, 32'h8);
    rst = 1'b1;
    #1;
    chk("s6_rst_req", req, 0);
    chk("s6_rst_valid", ivalid, 0);
    chk("s6_rst_addr", addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("s6_rst_misalign", misalign, 0);
`endif
    step();
    rst = 1'b0;
    rv_force = 1'b1;
    drive(0, 0, 0, 0);
    chk("s6_c0_req", req, 1);
    chk("s6_c0_addr", addr, 32'h0);
    step();
    rv_force = 1'b0;
    drive(0, 0, 0, 0);
    chk("s6_stray_valid", ivalid, 0);
    chk("s6_c1_req", req, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
